// File: rtl/divider.sv
// Sequential 16-bit restoring divider: result = {remainder, quotient}, flagged by validity.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands with sign fix-up.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        control,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        validity,
  output logic [31:0] result
);
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e         state_q, state_d;
  logic           ctrl_q, ctrl_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic           validity_q, validity_d;
  logic [2*W-1:0] result_q, result_d;

  logic           start_c, accept_c, last_c, fit_c;
  logic [W+1:0]   shift_c, diff_c;
  logic [W:0]     rem_step_c;
  logic [W-1:0]   quo_step_c, q_fin_c, r_fin_c, dvd_in_c, dvs_in_c;

`ifdef DIVIDER_SIGNED_EN
  logic dneg_q, dneg_d, qneg_q, qneg_d;
`endif

  assign start_c  = control & ~ctrl_q;
  assign accept_c = start_c && (state_q != BUSY);
  assign last_c   = (cnt_q == CW'(W - 1));

  // Operand conditioning at start and one restoring step plus final fix-up
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_in_c = dividend[W-1] ? W'(-dividend) : dividend;
    dvs_in_c = divisor[W-1]  ? W'(-divisor)  : divisor;
`else
    dvd_in_c = dividend;
    dvs_in_c = divisor;
`endif
    // Upper bit of rem_q is always 0 after a step, so the borrow of diff_c is exact
    shift_c    = {1'b0, rem_q, quo_q[W-1]};
    diff_c     = shift_c - {2'b00, dvsr_q};
    fit_c      = ~diff_c[W+1];
    rem_step_c = fit_c ? diff_c[W:0] : shift_c[W:0];
    quo_step_c = {quo_q[W-2:0], fit_c};
`ifdef DIVIDER_SIGNED_EN
    q_fin_c = (dvsr_q == '0) ? '1 : (qneg_q ? W'(-quo_step_c) : quo_step_c);
    r_fin_c = dneg_q ? W'(-rem_step_c[W-1:0]) : rem_step_c[W-1:0];
`else
    q_fin_c = quo_step_c;
    r_fin_c = rem_step_c[W-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_c) state_d = BUSY;
      BUSY:       if (last_c)  state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    ctrl_d     = control;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    validity_d = validity_q;
    result_d   = result_q;
`ifdef DIVIDER_SIGNED_EN
    dneg_d     = dneg_q;
    qneg_d     = qneg_q;
`endif
    if (accept_c) begin
      quo_d      = dvd_in_c;
      dvsr_d     = dvs_in_c;
      rem_d      = '0;
      cnt_d      = '0;
      validity_d = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      dneg_d     = dividend[W-1];
      qneg_d     = dividend[W-1] ^ divisor[W-1];
`endif
    end else if (state_q == BUSY) begin
      rem_d = rem_step_c;
      quo_d = quo_step_c;
      cnt_d = cnt_q + CW'(1);
      if (last_c) begin
        result_d   = {r_fin_c, q_fin_c};
        validity_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      validity_q <= 1'b0;
      result_q   <= '0;
`ifdef DIVIDER_SIGNED_EN
      dneg_q     <= 1'b0;
      qneg_q     <= 1'b0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      validity_q <= validity_d;
      result_q   <= result_d;
`ifdef DIVIDER_SIGNED_EN
      dneg_q     <= dneg_d;
      qneg_q     <= qneg_d;
`endif
    end
  end

  assign validity = validity_q;
  assign result   = result_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table, corner sequences and random operands
// compared against an arithmetic reference model.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        control;
  logic [15:0] dividend, divisor;
  logic        validity;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  divider dut (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .dividend (dividend),
    .divisor  (divisor),
    .validity (validity),
    .result   (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
`ifdef DIVIDER_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {a, 16'hFFFF};
    return {16'(sa % sb), 16'(sa / sb)};
`else
    int unsigned ua, ub;
    ua = 32'(a);
    ub = 32'(b);
    if (ub == 0) return {a, 16'hFFFF};
    return {16'(ua % ub), 16'(ua / ub)};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Assumes control is already rising before the next edge (the start edge)
  task automatic run_div(input logic [31:0] exp, input bit glitch, input string name);
    @(posedge clk); #1;
    check({name, " valid_at_start"}, 32'(validity), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (glitch && i == 3) control = 1'b0;
      else if (glitch && i == 5) begin
        control  = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
      end else begin
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      @(posedge clk); #1;
      if (i == 15) check({name, " valid_early"}, 32'(validity), 32'd0);
    end
    check({name, " valid"}, 32'(validity), 32'd1);
    check({name, " result"}, result, exp);
  endtask

  task automatic start_req(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    control = 1'b0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    control  = 1'b1;
  endtask

  task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input bit glitch, input string name);
    start_req(a, b);
    run_div(exp, glitch, name);
  endtask

  vec_t vecs[$];

  initial begin
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{16'hFFCD, 16'd5,    32'hFFFF_FFF6});
    vecs.push_back('{16'd51,   16'hFFFB, 32'h0001_FFF6});
    vecs.push_back('{16'hFFCD, 16'hFFFB, 32'hFFFF_000A});
    vecs.push_back('{16'h8000, 16'hFFFF, 32'h0000_8000});
    vecs.push_back('{16'd1234, 16'd0,    32'h04D2_FFFF});
    vecs.push_back('{16'hFB2E, 16'd0,    32'hFB2E_FFFF});
    vecs.push_back('{16'd7,    16'd9,    32'h0007_0000});
`else
    vecs.push_back('{16'd65535, 16'd1,     32'h0000_FFFF});
    vecs.push_back('{16'd7,     16'd9,     32'h0007_0000});
    vecs.push_back('{16'd1234,  16'd0,     32'h04D2_FFFF});
    vecs.push_back('{16'd0,     16'd0,     32'h0000_FFFF});
    vecs.push_back('{16'd65535, 16'd65535, 32'h0000_0001});
    vecs.push_back('{16'd1,     16'd65535, 32'h0001_0000});
    vecs.push_back('{16'd1000,  16'd3,     32'h0001_014D});
    vecs.push_back('{16'd100,   16'd100,   32'h0000_0001});
`endif

    // control held high through reset release starts on the first edge after release
    rst = 1'b1; control = 1'b1; dividend = 16'd51; divisor = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset validity", 32'(validity), 32'd0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_div(32'h0001_000A, 1'b0, "held_start");
    repeat (20) @(posedge clk);
    #1;
    check("no_retrigger valid", 32'(validity), 32'd1);
    check("no_retrigger result", result, 32'h0001_000A);

    foreach (vecs[i]) do_div(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

    // DONE holds
    @(negedge clk);
    control = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("done_hold valid", 32'(validity), 32'd1);
    check("done_hold result", result, vecs[vecs.size()-1].exp);

    // Second start edge while BUSY is ignored
    do_div(16'd1000, 16'd3, ref_div(16'd1000, 16'd3), 1'b1, "busy_restart");

    // Reset mid-division aborts immediately
    start_req(16'd200, 16'd7);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort validity", 32'(validity), 32'd0);
    check("abort result", result, 32'h0);
    @(negedge clk);
    control = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("after_abort idle", 32'(validity), 32'd0);
    do_div(16'd200, 16'd7, 32'h0004_001C, 1'b0, "post_abort");

    // Random operands against the model, biased toward small and zero divisors
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      do_div(a, b, ref_div(a, b), 1'b0, $sformatf("rand%0d_%h_%h", n, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Sequential 16-bit restoring integer divider. Takes a 16-bit dividend and a 16-bit divisor and produces a packed 32-bit result: remainder in the upper half, quotient in the lower half. The start is edge-triggered from `control`, the operation is iterative, and completion is flagged by `validity`. The block sits as a multi-cycle functional unit beside the ALU in the MIPS datapath.

## Interface
- No parameters; operand width fixed at 16 bits.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `control` input 1: start request; a 0→1 transition (sampled on `clk`) launches a division.
- `dividend` input 16: numerator; sampled only at start.
- `divisor` input 16: denominator; sampled only at start.
- `validity` output 1: high while `result` holds a completed division.
- `result` output 32: `{remainder[15:0], quotient[15:0]}`; registered.

## Operation
- Internal registers:
  - `ctrl_q`: previous `control`.
  - State: IDLE, BUSY, DONE.
  - 5-bit iteration counter.
  - 17-bit partial remainder.
  - 16-bit quotient shift register.
  - 16-bit latched divisor.
- Start condition: `control & ~ctrl_q`.
  - Accepted in IDLE or DONE.
  - Ignored in BUSY; no restart or abort.
- On start:
  - Latch `dividend` and `divisor`.
  - Clear the partial remainder and the counter.
  - Clear `validity`.
  - Go to BUSY.
- Each BUSY cycle (16 total), restoring step:
  - Shift the remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- After the 16th step:
  - Write `result`.
  - Set `validity=1`.
  - Go to DONE.
- DONE: `result` and `validity` hold until the next start or `rst`.
- A level held high on `control` does not retrigger. A new division requires `control` to return to 0 for at least one clock.
- Divide by zero (latched divisor = 0):
  - Still takes the full latency.
  - quotient = 16'hFFFF, remainder = dividend.
  - `validity` = 1.
- Arithmetic is unsigned unless the signed option is compiled in (see Configuration).

## Timing
- Reset values:
  - `validity=0`, `result=32'h0`.
  - State IDLE.
  - `ctrl_q=0`.
  - All datapath registers 0.
- Because `ctrl_q` resets to 0, a `control` held high through reset release starts a division on the first clock edge after `rst` falls.
- Latency:
  - Start detected at edge N.
  - BUSY edges N+1 … N+16.
  - `result` and `validity` update at edge N+16, i.e. 16 cycles after start.
- `validity` drops to 0 at the edge that accepts a new start.
- Operand inputs may change freely after the start edge.
- `rst` asserted mid-division:
  - Abort immediately and return all outputs to reset values.
  - No partial result is produced.

## Configuration
- Macro `DIVIDER_SIGNED_EN`.
- Defined: operands are two's complement.
  - Magnitudes are taken at start; signs are fixed up when `result` is written.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - -32768 / -1 gives quotient 16'h8000 (wraps), remainder 0.
  - Divide by zero gives quotient 16'hFFFF, remainder = dividend.
  - Latency unchanged.
- Undefined: purely unsigned division as described above.

## Test plan
- Reset, then `control` held at 1, dividend=51, divisor=5 → at the 16th edge after start, `validity=1`, `result=32'h0001_000A`. No retrigger while `control` stays high.
- dividend=65535, divisor=1 → `result=32'h0000_FFFF`. Then pulse `control` 0→1 with dividend=7, divisor=9 → `validity` falls at the start edge, then `result=32'h0007_0000`.
- divisor=0, dividend=1234 → after 16 cycles, `result={16'd1234,16'hFFFF}`, `validity=1`.
- `rst` pulsed 5 cycles into a division → `validity=0`, `result=0` immediately. A new start after release completes correctly.
- Second start edge during BUSY → ignored; the original operands' result appears at the original time.
- With `DIVIDER_SIGNED_EN`: -51 / 5 → quotient -10 (16'hFFF6), remainder -1 (16'hFFFF).
